// File: rtl/mdu_iter_if.sv
// Handshake and result bundle between the E-stage pipeline and the iterative MDU.
// The master side drives the operation; the slave side (the MDU) returns status and HI/LO.
interface mdu_iter_if #(
  parameter int DATA_W = 32
);
  logic              en;
  logic [3:0]        op;
  logic [DATA_W-1:0] rs;
  logic [DATA_W-1:0] rt;
  logic              start;
  logic              busy;
  logic              stall_src;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output en, op, rs, rt,
    input  start, busy, stall_src, rd_data, hi, lo
  );

  modport slave (
    input  en, op, rs, rt,
    output start, busy, stall_src, rd_data, hi, lo
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: result is computed at start, held in pend_hi/pend_lo,
// and committed to HI/LO after a fixed busy time so the hazard unit sees realistic latency.
module mdu_iter #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  mdu_iter_if.slave   m
);

  localparam int DATA_W = 32;
  localparam int MAXC   = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W  = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  hi_q, lo_q, pend_hi, pend_lo;
  logic [2*DATA_W-1:0] res;
  logic               busy, start, commit, is_mdu, is_mul;

  function automatic logic [2*DATA_W-1:0] mul_fn(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b,
                                                  input logic sgn);
    logic signed [2*DATA_W-1:0] ax, bx;
    ax = sgn ? {{DATA_W{a[DATA_W-1]}}, a} : {{DATA_W{1'b0}}, a};
    bx = sgn ? {{DATA_W{b[DATA_W-1]}}, b} : {{DATA_W{1'b0}}, b};
    return ax * bx;
  endfunction

  // Returns {remainder, quotient}; divide-by-zero keeps the current HI/LO so the commit is a no-op.
  function automatic logic [2*DATA_W-1:0] div_fn(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b,
                                                  input logic sgn,
                                                  input logic [DATA_W-1:0] cur_hi,
                                                  input logic [DATA_W-1:0] cur_lo);
    logic signed [DATA_W-1:0] as, bs, qs, rms;
    if (b == '0) return {cur_hi, cur_lo};
    if (sgn) begin
      if (a == {1'b1, {(DATA_W-1){1'b0}}} && b == {DATA_W{1'b1}})
        return {{DATA_W{1'b0}}, a};
      as  = a;
      bs  = b;
      qs  = as / bs;
      rms = as % bs;
      return {rms, qs};
    end
    return {a % b, a / b};
  endfunction

  assign busy   = (state_q == RUN);
  assign is_mdu = (m.op == OP_MULT) || (m.op == OP_MULTU) || (m.op == OP_DIV) || (m.op == OP_DIVU);
  assign is_mul = (m.op == OP_MULT) || (m.op == OP_MULTU);
  assign start  = m.en && is_mdu && !busy;

  always_comb begin
    res = {hi_q, lo_q};
    case (m.op)
      OP_MULT:  res = mul_fn(m.rs, m.rt, 1'b1);
      OP_MULTU: res = mul_fn(m.rs, m.rt, 1'b0);
      OP_DIV:   res = div_fn(m.rs, m.rt, 1'b1, hi_q, lo_q);
      OP_DIVU:  res = div_fn(m.rs, m.rt, 1'b0, hi_q, lo_q);
      default:  res = {hi_q, lo_q};
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = is_mul ? MUL_LOAD : DIV_LOAD;
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start) {pend_hi, pend_lo} <= res;
      // Moves only land while idle; commit can only happen in RUN, so they never collide.
      if (commit) begin
        hi_q <= pend_hi;
        lo_q <= pend_lo;
      end else if (m.en && !busy) begin
        if (m.op == OP_MTHI) hi_q <= m.rs;
        if (m.op == OP_MTLO) lo_q <= m.rs;
      end
    end
  end

  assign m.start     = start;
  assign m.busy      = busy;
  assign m.stall_src = start | busy;
  assign m.hi        = hi_q;
  assign m.lo        = lo_q;
  assign m.rd_data   = (m.op == OP_MFHI) ? hi_q :
                       (m.op == OP_MFLO) ? lo_q : '0;

endmodule
